// File: rtl/vram_arb_if.sv
// Request/response bundle between the two VRAM requesters (video, register port) and vram_arb.
// The master modport is the requester side and the slave modport is the arbiter side.
interface vram_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic                  vgen_sel;
  logic [ADDR_W-1:0]     vgen_addr;
  logic                  vgen_ack;
  logic                  vgen_rd_valid;
  logic [DATA_W-1:0]     vgen_data_out;

  logic                  regs_sel;
  logic                  regs_wr_en;
  logic [DATA_W/4-1:0]   regs_wr_mask;
  logic [ADDR_W-1:0]     regs_addr;
  logic [DATA_W-1:0]     regs_data_in;
  logic                  regs_ack;
  logic                  regs_rd_valid;
  logic [DATA_W-1:0]     regs_data_out;

  modport master (
    output vgen_sel, vgen_addr,
    input  vgen_ack, vgen_rd_valid, vgen_data_out,
    output regs_sel, regs_wr_en, regs_wr_mask, regs_addr, regs_data_in,
    input  regs_ack, regs_rd_valid, regs_data_out
  );

  modport slave (
    input  vgen_sel, vgen_addr,
    output vgen_ack, vgen_rd_valid, vgen_data_out,
    input  regs_sel, regs_wr_en, regs_wr_mask, regs_addr, regs_data_in,
    output regs_ack, regs_rd_valid, regs_data_out
  );
endinterface

// File: rtl/vram_arb.sv
// Banked video RAM shared by a read-only video port and a masked read/write register port.
// Different-bank requests proceed in parallel; same-bank conflicts favour video with a starvation guard.
module vram_arb #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BANK_BITS = 2,
  parameter int MAX_WAIT  = 4
) (
  input logic       clk,
  input logic       reset,
  vram_arb_if.slave bus
);
  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam int OFF_W     = ADDR_W - BANK_BITS;
  localparam int MASK_W    = DATA_W / 4;
  localparam int WAIT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [BANK_BITS-1:0] vgen_bank, regs_bank;
  logic [OFF_W-1:0]     vgen_off, regs_off;
  logic                 conflict, force_regs;
  logic                 vgen_grant, regs_grant;
  logic [WAIT_W-1:0]    wait_cnt;

  assign vgen_bank = bus.vgen_addr[ADDR_W-1 -: BANK_BITS];
  assign regs_bank = bus.regs_addr[ADDR_W-1 -: BANK_BITS];
  assign vgen_off  = bus.vgen_addr[OFF_W-1:0];
  assign regs_off  = bus.regs_addr[OFF_W-1:0];

  assign conflict   = bus.vgen_sel && bus.regs_sel && (vgen_bank == regs_bank);
  assign force_regs = (MAX_WAIT != 0) && (wait_cnt == WAIT_W'(MAX_WAIT));

  // Grants are combinational so the bank access happens on the very edge that acks it.
  assign vgen_grant = !reset && bus.vgen_sel && !(conflict && force_regs);
  assign regs_grant = !reset && bus.regs_sel && (!conflict || force_regs);

  assign bus.vgen_ack = vgen_grant;
  assign bus.regs_ack = regs_grant;

  // NOTE: all sequential state uses non-blocking assignments so every block samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (regs_grant) begin
      wait_cnt <= '0;
    end else if (conflict && (wait_cnt != WAIT_W'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  logic [DATA_W-1:0] bank_rd [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [2**OFF_W];
    logic [DATA_W-1:0] rd_q;
    logic              v_hit, r_hit;
    logic [OFF_W-1:0]  addr;

    // Arbitration guarantees at most one hit per bank per cycle, so each bank is a true single-port RAM.
    assign v_hit = vgen_grant && (vgen_bank == BANK_BITS'(b));
    assign r_hit = regs_grant && (regs_bank == BANK_BITS'(b));
    assign addr  = r_hit ? regs_off : vgen_off;

    // NOTE: the RAM array and its read register carry no reset so the bank maps onto vendor block RAM.
    always_ff @(posedge clk) begin
      if (v_hit || r_hit) begin
        rd_q <= mem[addr];
        if (r_hit && bus.regs_wr_en) begin
          for (int i = 0; i < MASK_W; i++) begin
            if (bus.regs_wr_mask[i]) mem[addr][4*i +: 4] <= bus.regs_data_in[4*i +: 4];
          end
        end
      end
    end

    assign bank_rd[b] = rd_q;
  end

  logic                 vgen_valid_q, regs_valid_q;
  logic [BANK_BITS-1:0] vgen_bank_q, regs_bank_q;
  logic [DATA_W-1:0]    vgen_hold_q, regs_hold_q;

  // Each port remembers which bank it read so a later access by the other port cannot steer its data.
  always_ff @(posedge clk) begin
    if (reset) begin
      vgen_valid_q <= 1'b0;
      regs_valid_q <= 1'b0;
      vgen_bank_q  <= '0;
      regs_bank_q  <= '0;
      vgen_hold_q  <= '0;
      regs_hold_q  <= '0;
    end else begin
      vgen_valid_q <= vgen_grant;
      regs_valid_q <= regs_grant && !bus.regs_wr_en;
      if (vgen_grant) vgen_bank_q <= vgen_bank;
      if (regs_grant && !bus.regs_wr_en) regs_bank_q <= regs_bank;
      if (vgen_valid_q) vgen_hold_q <= bank_rd[vgen_bank_q];
      if (regs_valid_q) regs_hold_q <= bank_rd[regs_bank_q];
    end
  end

  assign bus.vgen_rd_valid = vgen_valid_q;
  assign bus.regs_rd_valid = regs_valid_q;
  assign bus.vgen_data_out = vgen_valid_q ? bank_rd[vgen_bank_q] : vgen_hold_q;
  assign bus.regs_data_out = regs_valid_q ? bank_rd[regs_bank_q] : regs_hold_q;
endmodule

// File: tb/tb_vram_arb.sv
// Directed bench for vram_arb: a table of single-cycle vectors plus hand sequences for
// same-bank starvation, video streaming and reset during a pending read.
module tb_vram_arb;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int BANK_BITS  = 2;
  localparam int MAX_WAIT   = 4;
  localparam int BANK_DEPTH = 2 ** (ADDR_W - BANK_BITS);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANK_BITS(BANK_BITS), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        vs;
    logic [15:0] va;
    logic        rs;
    logic        wr;
    logic [3:0]  mask;
    logic [15:0] ra;
    logic [15:0] din;
    logic        x_vack;
    logic        x_rack;
    logic        x_vvalid;
    logic [15:0] x_vdata;
    logic        x_rvalid;
    logic [15:0] x_rdata;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic vs, input logic [15:0] va, input logic rs, input logic wr,
                       input logic [3:0] mask, input logic [15:0] ra, input logic [15:0] din);
    bus.vgen_sel     = vs;
    bus.vgen_addr    = va;
    bus.regs_sel     = rs;
    bus.regs_wr_en   = wr;
    bus.regs_wr_mask = mask;
    bus.regs_addr    = ra;
    bus.regs_data_in = din;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic vs, input logic [15:0] va, input logic rs, input logic wr,
                              input logic [3:0] mask, input logic [15:0] ra, input logic [15:0] din,
                              input logic xva, input logic xra, input logic xvv, input logic [15:0] xvd,
                              input logic xrv, input logic [15:0] xrd);
    vec_t v;
    v.vs = vs; v.va = va; v.rs = rs; v.wr = wr; v.mask = mask; v.ra = ra; v.din = din;
    v.x_vack = xva; v.x_rack = xra; v.x_vvalid = xvv; v.x_vdata = xvd;
    v.x_rvalid = xrv; v.x_rdata = xrd;
    return v;
  endfunction

  vec_t vecs[11];
  logic [15:0] pat[8];

  initial begin
    // Behavioural power-up contents of every bank.
    for (int i = 0; i < BANK_DEPTH; i++) begin
      dut.g_bank[0].mem[i] = 16'hdead;
      dut.g_bank[1].mem[i] = 16'hdead;
      dut.g_bank[2].mem[i] = 16'hdead;
      dut.g_bank[3].mem[i] = 16'hdead;
    end

    //            vs  va       rs  wr  mask  ra       din       vack rack vvld vdata    rvld rdata
    vecs[0]  = mk(0, 16'h0000, 1, 1, 4'hF, 16'h0005, 16'h1234, 0, 1, 0, 16'h0000, 0, 16'h0000);
    vecs[1]  = mk(0, 16'h0000, 1, 0, 4'h0, 16'h0005, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h1234);
    vecs[2]  = mk(0, 16'h0000, 1, 1, 4'h5, 16'h0005, 16'hABCD, 0, 1, 0, 16'h0000, 0, 16'h1234);
    vecs[3]  = mk(0, 16'h0000, 1, 0, 4'h0, 16'h0005, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h1B3D);
    vecs[4]  = mk(1, 16'h4000, 1, 1, 4'hF, 16'h8000, 16'h5A5A, 1, 1, 1, 16'hdead, 0, 16'h1B3D);
    vecs[5]  = mk(1, 16'h0005, 1, 0, 4'h0, 16'h8000, 16'h0000, 1, 1, 1, 16'h1B3D, 1, 16'h5A5A);
    vecs[6]  = mk(0, 16'h0000, 1, 1, 4'h0, 16'h8000, 16'hFFFF, 0, 1, 0, 16'h1B3D, 0, 16'h5A5A);
    vecs[7]  = mk(1, 16'hC123, 1, 0, 4'h0, 16'h8000, 16'h0000, 1, 1, 1, 16'hdead, 1, 16'h5A5A);
    vecs[8]  = mk(0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 0, 0, 0, 16'hdead, 0, 16'h5A5A);
    vecs[9]  = mk(0, 16'h0000, 1, 1, 4'h8, 16'h4001, 16'h0F0F, 0, 1, 0, 16'hdead, 0, 16'h5A5A);
    vecs[10] = mk(1, 16'h8000, 1, 0, 4'h0, 16'h4001, 16'h0000, 1, 1, 1, 16'h5A5A, 1, 16'h0EAD);

    // Reset: acks held low even with both requests raised.
    reset = 1'b1;
    drive(1'b1, 16'h0000, 1'b1, 1'b1, 4'hF, 16'h0000, 16'hFFFF);
    step();
    step();
    check("rst_vack", 32'(bus.vgen_ack), 32'd0);
    check("rst_rack", 32'(bus.regs_ack), 32'd0);
    check("rst_vvalid", 32'(bus.vgen_rd_valid), 32'd0);
    check("rst_rvalid", 32'(bus.regs_rd_valid), 32'd0);
    check("rst_vdata", 32'(bus.vgen_data_out), 32'd0);
    check("rst_rdata", 32'(bus.regs_data_out), 32'd0);
    check("rst_wait", 32'(dut.wait_cnt), 32'd0);
    idle();
    reset = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].vs, vecs[i].va, vecs[i].rs, vecs[i].wr, vecs[i].mask, vecs[i].ra, vecs[i].din);
      #2;
      check($sformatf("v%0d_vack", i), 32'(bus.vgen_ack), 32'(vecs[i].x_vack));
      check($sformatf("v%0d_rack", i), 32'(bus.regs_ack), 32'(vecs[i].x_rack));
      step();
      check($sformatf("v%0d_vvalid", i), 32'(bus.vgen_rd_valid), 32'(vecs[i].x_vvalid));
      check($sformatf("v%0d_vdata", i), 32'(bus.vgen_data_out), 32'(vecs[i].x_vdata));
      check($sformatf("v%0d_rvalid", i), 32'(bus.regs_rd_valid), 32'(vecs[i].x_rvalid));
      check($sformatf("v%0d_rdata", i), 32'(bus.regs_data_out), 32'(vecs[i].x_rdata));
    end
    idle();
    step();

    // Same-bank starvation: video streams bank 0 while the register read of 0x0010 waits.
    begin
      logic [15:0] va;
      logic        vack;
      va = 16'h0000;
      for (int c = 1; c <= 5; c++) begin
        drive(1'b1, va, 1'b1, 1'b0, 4'h0, 16'h0010, 16'h0000);
        #2;
        vack = bus.vgen_ack;
        check($sformatf("starve%0d_vack", c), 32'(bus.vgen_ack), (c < 5) ? 32'd1 : 32'd0);
        check($sformatf("starve%0d_rack", c), 32'(bus.regs_ack), (c < 5) ? 32'd0 : 32'd1);
        step();
        if (vack) va = va + 16'd1;
        if (c == 4) check("starve_wait_max", 32'(dut.wait_cnt), 32'd4);
      end
      check("starve_wait_clr", 32'(dut.wait_cnt), 32'd0);
      check("starve_rvalid", 32'(bus.regs_rd_valid), 32'd1);
      check("starve_rdata", 32'(bus.regs_data_out), 32'hdead);
      check("starve_vvalid", 32'(bus.vgen_rd_valid), 32'd0);
      drive(1'b1, va, 1'b1, 1'b0, 4'h0, 16'h0020, 16'h0000);
      #2;
      check("retry_vack", 32'(bus.vgen_ack), 32'd1);
      check("retry_rack", 32'(bus.regs_ack), 32'd0);
      step();
      check("retry_wait", 32'(dut.wait_cnt), 32'd1);
      idle();
      step();
      step();
    end

    // Preload 0x0100..0x0107 through the register port, then stream them on the video port.
    for (int i = 0; i < 8; i++) begin
      pat[i] = 16'hA000 + 16'(i) * 16'h0111;
      drive(1'b0, 16'h0, 1'b1, 1'b1, 4'hF, 16'h0100 + 16'(i), pat[i]);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
      #2;
      check($sformatf("stream%0d_vack", i), 32'(bus.vgen_ack), 32'd1);
      step();
      check($sformatf("stream%0d_vvalid", i), 32'(bus.vgen_rd_valid), 32'd1);
      check($sformatf("stream%0d_vdata", i), 32'(bus.vgen_data_out), 32'(pat[i]));
    end
    idle();
    step();
    check("stream_end_vvalid", 32'(bus.vgen_rd_valid), 32'd0);
    check("stream_end_hold", 32'(bus.vgen_data_out), 32'(pat[7]));

    // Reset rises right after a granted read; the write attempted under reset must not land.
    drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0005, 16'h0000);
    #2;
    check("prerst_rack", 32'(bus.regs_ack), 32'd1);
    step();
    reset = 1'b1;
    drive(1'b1, 16'h4000, 1'b1, 1'b1, 4'hF, 16'h0005, 16'h0000);
    #2;
    check("inrst_vack", 32'(bus.vgen_ack), 32'd0);
    check("inrst_rack", 32'(bus.regs_ack), 32'd0);
    step();
    check("postrst_rvalid", 32'(bus.regs_rd_valid), 32'd0);
    check("postrst_rdata", 32'(bus.regs_data_out), 32'd0);
    check("postrst_vdata", 32'(bus.vgen_data_out), 32'd0);
    reset = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0005, 16'h0000);
    step();
    idle();
    check("reread_rvalid", 32'(bus.regs_rd_valid), 32'd1);
    check("reread_rdata", 32'(bus.regs_data_out), 32'h1B3D);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
